voting_machine: RTL and testbench



---
 rtl/voting_machine.sv | 98 +++++++++
 tb/tb_voting_machine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/voting_machine.sv
// Four-candidate voting core: debounced one-vote-per-press tallies plus a result display.
// Optional feature: define VOTE_TOTAL_EN to show the saturated grand total when no button is pressed in result mode.
module voting_machine #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [7:0] led
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Bit k of every 4-bit vector below refers to button k+1.
  logic [3:0]    btn_q;
  logic          mode_q;
  logic [DW-1:0] deb [4];
  logic [3:0]    lock;
  logic [3:0]    ack;
  logic [7:0]    count [4];

  logic [3:0]    accept;
  logic [3:0]    valid;
  logic [7:0]    result_led;

`ifdef VOTE_TOTAL_EN
  logic [9:0]    total;
  assign total = {2'b00, count[0]} + {2'b00, count[1]} + {2'b00, count[2]} + {2'b00, count[3]};
`endif

  // accept: this cycle the press reaches its debounce threshold; valid: it also is
  // the only button down, so the vote is counted rather than discarded.
  always_comb begin
    accept = 4'b0000;
    valid  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      accept[k] = !mode_q && btn_q[k] && (deb[k] == DEB_LAST) && !lock[k];
      valid[k]  = accept[k] && ((btn_q & ~(4'b0001 << k)) == 4'b0000);
    end
  end

  // Result display: lowest-numbered pressed button wins.
  always_comb begin
`ifdef VOTE_TOTAL_EN
    result_led = (total > 10'd255) ? 8'hFF : total[7:0];
`else
    result_led = 8'h00;
`endif
    if (btn_q[3]) result_led = count[3];
    if (btn_q[2]) result_led = count[2];
    if (btn_q[1]) result_led = count[1];
    if (btn_q[0]) result_led = count[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q  <= 4'b0000;
      mode_q <= 1'b0;
      lock   <= 4'b0000;
      ack    <= 4'b0000;
      led    <= 8'h00;
      for (int k = 0; k < 4; k++) begin
        deb[k]   <= '0;
        count[k] <= 8'h00;
      end
    end else begin
      btn_q  <= {button4, button3, button2, button1};
      mode_q <= mode;
      for (int k = 0; k < 4; k++) begin
        if (mode_q || !btn_q[k]) begin
          deb[k]  <= '0;
          lock[k] <= 1'b0;
          ack[k]  <= 1'b0;
        end else begin
          if (deb[k] != DEB_MAX) deb[k] <= deb[k] + 1'b1;
          if (accept[k]) begin
            lock[k] <= 1'b1;
            ack[k]  <= valid[k];
          end
        end
        if (valid[k] && (count[k] != 8'd255)) count[k] <= count[k] + 8'd1;
      end
      if (mode_q)
        led <= result_led;
      else if ((valid != 4'b0000) || ((ack & btn_q) != 4'b0000))
        led <= 8'hFF;
      else
        led <= 8'h00;
    end
  end

endmodule

// File: tb/tb_voting_machine.sv
// Randomized self-checking bench for voting_machine; the reference model works per press,
// not per cycle (a single-button press held >= DEBOUNCE_CYCLES is one vote).
module tb_voting_machine;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       button1 = 1'b0;
  logic       button2 = 1'b0;
  logic       button3 = 1'b0;
  logic       button4 = 1'b0;
  logic [7:0] led;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] tally [4];
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  voting_machine #(.DEBOUNCE_CYCLES(D)) dut (
    .clock  (clock),
    .reset  (reset),
    .mode   (mode),
    .button1(button1),
    .button2(button2),
    .button3(button3),
    .button4(button4),
    .led    (led)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] expected_result(input logic [3:0] mask);
    int sum;
    for (int k = 0; k < 4; k++)
      if (mask[k]) return tally[k];
`ifdef VOTE_TOTAL_EN
    sum = 0;
    for (int k = 0; k < 4; k++) sum += int'(tally[k]);
    return (sum > 255) ? 8'd255 : 8'(sum);
`else
    sum = 0;
    return 8'h00;
`endif
  endfunction

  task automatic drive(input logic [3:0] mask);
    button1 = mask[0];
    button2 = mask[1];
    button3 = mask[2];
    button4 = mask[3];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mode = 1'b0;
    drive(4'b0000);
    idle(10);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tally[k] = 8'h00;
    check_eq("reset_led", led, 8'h00);
  endtask

  task automatic set_mode(input logic m);
    mode = m;
    drive(4'b0000);
    idle(3);
  endtask

  // Vote-mode press: every button in mask held for hold cycles, then all released for gap (>=2).
  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    bit vote;
    int idx;
    vote = ($countones(mask) == 1) && (hold >= D);
    idx = 0;
    for (int k = 0; k < 4; k++) if (mask[k]) idx = k;
    drive(mask);
    for (int j = 1; j <= hold; j++) begin
      idle(1);
      check_eq("vote_led_hold", led, (vote && j >= D + 1) ? 8'hFF : 8'h00);
    end
    drive(4'b0000);
    idle(1);
    check_eq("vote_led_release", led, vote ? 8'hFF : 8'h00);
    idle(gap - 1);
    check_eq("vote_led_idle", led, 8'h00);
    if (vote && tally[idx] != 8'd255) tally[idx] = tally[idx] + 8'd1;
  endtask

  task automatic read_all(input string tag);
    set_mode(1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(4'(1 << k));
      exp_q.push_back(tally[k]);
      idle(2);
      check_eq(tag, led, exp_q.pop_front());
    end
    drive(4'b0000);
    idle(2);
    check_eq({tag, "_none"}, led, expected_result(4'b0000));
    set_mode(1'b0);
  endtask

  initial begin
    logic [3:0] m;
    do_reset();
    read_all("read_after_reset");

    // Two clean presses per candidate.
    for (int k = 0; k < 4; k++) begin
      press(4'(1 << k), 10, 5);
      press(4'(1 << k), 10, 5);
    end
    read_all("read_two_each");

    // Short pulse, boundary holds and a long hold.
    press(4'b0010, 3, 5);
    press(4'b0010, 50, 5);
    press(4'b0100, D - 1, 3);
    press(4'b0100, D, 3);
    press(4'b0101, 10, 5);
    read_all("read_pulse_hold");

    // Random presses, single and simultaneous.
    repeat (40) begin
      if ($urandom_range(0, 1) == 0) m = 4'(1 << $urandom_range(0, 3));
      else m = 4'($urandom_range(1, 15));
      press(m, int'($urandom_range(1, 12)), int'($urandom_range(2, 5)));
    end
    read_all("read_random");

    // Held across a vote->result->vote mode change: a second vote is required.
    drive(4'b0001);
    idle(10);
    mode = 1'b1;
    idle(3);
    mode = 1'b0;
    idle(10);
    check_eq("mode_change_led", led, 8'hFF);
    drive(4'b0000);
    idle(3);
    for (int n = 0; n < 2; n++) if (tally[0] != 8'd255) tally[0] = tally[0] + 8'd1;
    read_all("read_mode_change");

    // Result-mode presses with random masks never alter a tally.
    set_mode(1'b1);
    repeat (20) begin
      m = 4'($urandom_range(0, 15));
      drive(m);
      idle(2);
      check_eq("result_priority", led, expected_result(m));
    end
    set_mode(1'b0);

    // Saturation on button4.
    repeat (260) press(4'b1000, 5, 2);
    read_all("read_saturated");

    // Reset wipes everything; later result presses keep tallies at zero.
    do_reset();
    read_all("read_after_reset2");
    set_mode(1'b1);
    repeat (8) begin
      m = 4'($urandom_range(1, 15));
      drive(m);
      idle(6);
    end
    set_mode(1'b0);
    read_all("read_result_no_vote");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
